// File: rtl/bcd_sseg_scan.sv
// bcd_sseg_scan: four-digit, common-anode, time-multiplexed seven-segment driver.
// Digits are loaded into a staging buffer by Ld and copied into the display
// shadow only at a frame boundary, so a frame never shows a mix of old and new
// values. Ack pulses for one cycle when staged values reach the shadow.
// Optional build macro LEADING_ZERO_BLANK_EN blanks leading zero digits.
module bcd_sseg_scan #(
  parameter int REFRESH_DIV = 100000,
  parameter int CNT_W       = 17
) (
  input  logic       Clk,
  input  logic       Clr,
  input  logic       En,
  input  logic       Ld,
  input  logic [3:0] D1,
  input  logic [3:0] D2,
  input  logic [3:0] D3,
  input  logic [3:0] D4,
  input  logic [3:0] Dp,
  output logic [6:0] Seg,
  output logic       DpOut,
  output logic [3:0] An,
  output logic       Ack
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(REFRESH_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic [15:0]      stg_q, stg_d;
  logic [3:0]       stg_dp_q, stg_dp_d;
  logic             pend_q, pend_d;
  logic [15:0]      sh_q, sh_d;
  logic [3:0]       sh_dp_q, sh_dp_d;
  logic [3:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic             dp_q, dp_d;
  logic             ack_q, ack_d;

  logic             tc, frame_end, blank;
  logic [3:0]       cur;

  // Active-low segment pattern {g,f,e,d,c,b,a}; non-BCD codes show a dash.
  function automatic logic [6:0] dec7(input logic [3:0] v);
    case (v)
      4'd0:    dec7 = 7'b1000000;
      4'd1:    dec7 = 7'b1111001;
      4'd2:    dec7 = 7'b0100100;
      4'd3:    dec7 = 7'b0110000;
      4'd4:    dec7 = 7'b0011001;
      4'd5:    dec7 = 7'b0010010;
      4'd6:    dec7 = 7'b0000010;
      4'd7:    dec7 = 7'b1111000;
      4'd8:    dec7 = 7'b0000000;
      4'd9:    dec7 = 7'b0010000;
      default: dec7 = 7'b0111111;
    endcase
  endfunction

  // Next-state: prescaler/slot scan, staging/shadow handoff and output decode.
  always_comb begin
    tc        = En && (cnt_q == LAST);
    frame_end = tc && (idx_q == 2'd3);

    cnt_d = cnt_q;
    idx_d = idx_q;
    if (En) begin
      if (tc) begin
        cnt_d = '0;
        idx_d = idx_q + 2'd1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    stg_d    = stg_q;
    stg_dp_d = stg_dp_q;
    pend_d   = pend_q;
    sh_d     = sh_q;
    sh_dp_d  = sh_dp_q;
    if (frame_end && Ld) begin
      // load landing on the boundary bypasses staging entirely
      sh_d    = {D4, D3, D2, D1};
      sh_dp_d = Dp;
      pend_d  = 1'b0;
    end else if (frame_end && pend_q) begin
      sh_d    = stg_q;
      sh_dp_d = stg_dp_q;
      pend_d  = 1'b0;
    end else if (Ld) begin
      stg_d    = {D4, D3, D2, D1};
      stg_dp_d = Dp;
      pend_d   = 1'b1;
    end
    ack_d = frame_end && (Ld || pend_q);

    cur = sh_q[{idx_q, 2'b00} +: 4];
`ifdef LEADING_ZERO_BLANK_EN
    case (idx_q)
      2'd3:    blank = (sh_q[15:12] == 4'd0);
      2'd2:    blank = (sh_q[15:8]  == 8'd0);
      2'd1:    blank = (sh_q[15:4]  == 12'd0);
      default: blank = 1'b0;
    endcase
`else
    blank = 1'b0;
`endif

    an_d  = En ? ~(4'b0001 << idx_q) : 4'b1111;
    seg_d = (En && !blank) ? dec7(cur) : 7'b1111111;
    dp_d  = En ? ~sh_dp_q[idx_q] : 1'b1;
  end

  // State and registered outputs; Clr overrides everything.
  always_ff @(posedge Clk) begin
    if (Clr) begin
      cnt_q    <= '0;
      idx_q    <= 2'd0;
      stg_q    <= '0;
      stg_dp_q <= '0;
      pend_q   <= 1'b0;
      sh_q     <= '0;
      sh_dp_q  <= '0;
      an_q     <= 4'b1111;
      seg_q    <= 7'b1111111;
      dp_q     <= 1'b1;
      ack_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      stg_q    <= stg_d;
      stg_dp_q <= stg_dp_d;
      pend_q   <= pend_d;
      sh_q     <= sh_d;
      sh_dp_q  <= sh_dp_d;
      an_q     <= an_d;
      seg_q    <= seg_d;
      dp_q     <= dp_d;
      ack_q    <= ack_d;
    end
  end

  assign An    = an_q;
  assign Seg   = seg_q;
  assign DpOut = dp_q;
  assign Ack   = ack_q;

endmodule
